// File: rtl/nn_pkg.sv
// Shared definitions for the MLP inference sequencer: FSM states, layer_sel codes and
// default layer sizes.
package nn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StL1Clr,
        StL1Acc,
        StL1Bias,
        StL2Clr,
        StL2Acc,
        StL2Bias,
        StDone
    } nn_state_e;

    localparam logic [1:0] LSEL_IDLE = 2'd0;
    localparam logic [1:0] LSEL_L1   = 2'd1;
    localparam logic [1:0] LSEL_L2   = 2'd2;

    localparam int unsigned N_IN_DEFAULT  = 784;
    localparam int unsigned N_HID_DEFAULT = 32;

endpackage

// File: rtl/nn_layer_seq.sv
// Two-layer MLP sequencer: walks layer-1 then layer-2 rows, issuing clear/MAC/bias strobes.
// Define NN_SEQ_CYCLE_CNT_EN to add the saturating busy-cycle counter output cycle_cnt.
module nn_layer_seq
    import nn_pkg::*;
#(
    parameter int unsigned N_IN  = N_IN_DEFAULT,
    parameter int unsigned N_HID = N_HID_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        stall,
    output logic [1:0]  layer_sel,
    output logic [9:0]  row_idx,
    output logic        acc_clr,
    output logic        mac_en,
    output logic        bias_en,
    output logic        hid_valid,
    output logic        busy,
`ifdef NN_SEQ_CYCLE_CNT_EN
    output logic        done,
    output logic [15:0] cycle_cnt
`else
    output logic        done
`endif
);

    nn_state_e  state_q, state_d;
    logic [9:0] row_q, row_d;
    logic [9:0] last_row;

    assign last_row = (state_q == StL1Acc) ? 10'(N_IN - 1) : 10'(N_HID - 1);

    always_comb begin
        state_d = state_q;
        row_d   = '0;
        unique case (state_q)
            StIdle:   if (start) state_d = StL1Clr;
            StL1Clr:  state_d = StL1Acc;
            StL1Acc, StL2Acc: begin
                row_d = row_q;
                if (!stall) begin
                    if (row_q == last_row) begin
                        row_d   = '0;
                        state_d = (state_q == StL1Acc) ? StL1Bias : StL2Bias;
                    end else begin
                        row_d = row_q + 10'd1;
                    end
                end
            end
            StL1Bias: if (!stall) state_d = StL2Clr;
            StL2Clr:  state_d = StL2Acc;
            StL2Bias: if (!stall) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Abort wins over stall and over any pending transition.
        if (abort) begin
            state_d = StIdle;
            row_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        layer_sel = LSEL_IDLE;
        acc_clr   = 1'b0;
        mac_en    = 1'b0;
        bias_en   = 1'b0;
        hid_valid = 1'b0;
        busy      = (state_q != StIdle);
        done      = 1'b0;
        unique case (state_q)
            StL1Clr:  begin layer_sel = LSEL_L1; acc_clr = 1'b1; end
            StL1Acc:  begin layer_sel = LSEL_L1; mac_en = !stall; end
            StL1Bias: begin layer_sel = LSEL_L1; bias_en = !stall; end
            StL2Clr:  begin layer_sel = LSEL_L2; acc_clr = 1'b1; hid_valid = 1'b1; end
            StL2Acc:  begin layer_sel = LSEL_L2; mac_en = !stall; end
            StL2Bias: begin layer_sel = LSEL_L2; bias_en = !stall; end
            StDone:   done = 1'b1;
            default:  layer_sel = LSEL_IDLE;
        endcase
    end

    assign row_idx = row_q;

`ifdef NN_SEQ_CYCLE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == StIdle && start && !abort) begin
            cnt_q <= '0;
        end else if (busy && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_nn_layer_seq.sv
// Scoreboard bench for nn_layer_seq: a step-list reference model predicts every cycle's outputs,
// a negedge monitor pops and compares; directed scenarios also check end-to-end latencies.
module tb_nn_layer_seq;

    localparam int N_IN  = 784;
    localparam int N_HID = 32;
    // Step index layout of one inference: CLR, N_IN x ACC, BIAS, CLR, N_HID x ACC, BIAS, DONE
    localparam int S_L1_BIAS = N_IN + 1;
    localparam int S_L2_CLR  = N_IN + 2;
    localparam int S_L2_ACC0 = N_IN + 3;
    localparam int S_L2_BIAS = N_IN + N_HID + 3;
    localparam int S_DONE    = N_IN + N_HID + 4;

    typedef struct packed {
        logic [1:0]  lsel;
        logic [9:0]  row;
        logic        clr;
        logic        mac;
        logic        bias;
        logic        hid;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic stall = 1'b0;
    logic [1:0] layer_sel;
    logic [9:0] row_idx;
    logic acc_clr, mac_en, bias_en, hid_valid, busy, done;
    wire  logic [15:0] cycle_cnt;

    always #5 clk = ~clk;

    nn_layer_seq #(.N_IN(N_IN), .N_HID(N_HID)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .stall     (stall),
        .layer_sel (layer_sel),
        .row_idx   (row_idx),
        .acc_clr   (acc_clr),
        .mac_en    (mac_en),
        .bias_en   (bias_en),
        .hid_valid (hid_valid),
        .busy      (busy),
`ifdef NN_SEQ_CYCLE_CNT_EN
        .done      (done),
        .cycle_cnt (cycle_cnt)
`else
        .done      (done)
`endif
    );

`ifndef NN_SEQ_CYCLE_CNT_EN
    assign cycle_cnt = 16'h0;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   chk_en   = 1'b0;
    vec_t exp_q[$];

    int m_step = -1;        // -1 means idle
    int m_cnt  = 0;

    int done_cnt = 0, hid_cnt = 0, row100_cnt = 0, bias_cnt = 0, last_done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit stallable(input int s);
        return (s >= 1 && s <= N_IN) || s == S_L1_BIAS ||
               (s >= S_L2_ACC0 && s < S_L2_BIAS) || s == S_L2_BIAS;
    endfunction

    function automatic vec_t model_out(input int s, input logic sl, input int cnt);
        vec_t v;
        v = '0;
`ifdef NN_SEQ_CYCLE_CNT_EN
        v.cnt = 16'(cnt);
`endif
        if (s < 0) return v;
        v.busy = 1'b1;
        v.lsel = (s == S_DONE) ? 2'd0 : (s < S_L2_CLR ? 2'd1 : 2'd2);
        v.clr  = (s == 0 || s == S_L2_CLR);
        v.hid  = (s == S_L2_CLR);
        v.done = (s == S_DONE);
        if (s >= 1 && s <= N_IN) begin
            v.row = 10'(s - 1);
            v.mac = !sl;
        end
        if (s >= S_L2_ACC0 && s < S_L2_BIAS) begin
            v.row = 10'(s - S_L2_ACC0);
            v.mac = !sl;
        end
        v.bias = (s == S_L1_BIAS || s == S_L2_BIAS) && !sl;
        return v;
    endfunction

    task automatic model_advance(input logic st, input logic sl, input logic ab, input logic rs);
        if (rs) m_cnt = 0;
        else if (m_step < 0 && st && !ab) m_cnt = 0;
        else if (m_step >= 0 && m_cnt < 65535) m_cnt = m_cnt + 1;

        if (rs || ab) m_step = -1;
        else if (m_step < 0) begin
            if (st) m_step = 0;
        end else if (!(stallable(m_step) && sl)) begin
            m_step = (m_step == S_DONE) ? -1 : m_step + 1;
        end
    endtask

    task automatic drive_cycle(input logic st, input logic sl, input logic ab, input logic rs);
        vec_t e;
        @(posedge clk);
        #1;
        start = st;
        stall = sl;
        abort = ab;
        rst   = rs;
        e = model_out(m_step, sl, m_cnt);
        exp_q.push_back(e);
        chk_en = 1'b1;
        model_advance(st, sl, ab, rs);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one expected output vector per driven cycle
    always @(negedge clk) begin
        vec_t a, e;
        if (chk_en) begin
            a.lsel = layer_sel; a.row = row_idx; a.clr = acc_clr; a.mac = mac_en;
            a.bias = bias_en; a.hid = hid_valid; a.busy = busy; a.done = done;
            a.cnt  = cycle_cnt;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL outputs@%0d: got %h, expected nothing queued", cyc, a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs@%0d: got lsel=%0d row=%0d clr=%b mac=%b bias=%b hid=%b busy=%b done=%b cnt=%0d, expected lsel=%0d row=%0d clr=%b mac=%b bias=%b hid=%b busy=%b done=%b cnt=%0d",
                             cyc, a.lsel, a.row, a.clr, a.mac, a.bias, a.hid, a.busy, a.done,
                             a.cnt, e.lsel, e.row, e.clr, e.mac, e.bias, e.hid, e.busy, e.done,
                             e.cnt);
                end
            end
            if (done) begin done_cnt++; last_done_cyc = cyc; end
            if (hid_valid) hid_cnt++;
            if (bias_en) bias_cnt++;
            if (mac_en && layer_sel == 2'd1 && row_idx == 10'd100) row100_cnt++;
        end
    end

    // Offsets are cycles after the start pulse; negative disables that feature.
    task automatic run_scn(input string name, input int stall_at, input int stall_len,
                           input int abort_at, input bit use_rst, input int xs1, input int xs2,
                           input int pct, input int exp_lat);
        int  d0, h0, r0, b0, s;
        bit  fin;
        logic st, sl;
        d0 = done_cnt; h0 = hid_cnt; r0 = row100_cnt; b0 = bias_cnt; s = 0; fin = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (abort_at >= 0 && i > abort_at + 1) begin fin = 1'b1; break; end
            if (abort_at < 0 && done_cnt != d0 && i > xs1 && i > xs2) begin
                fin = 1'b1;
                break;
            end
            st = (i == 0 || i == xs1 || i == xs2);
            sl = (i >= stall_at && i < stall_at + stall_len && stall_at >= 0) ||
                 ($urandom_range(99) < pct);
            drive_cycle(st, sl, (i == abort_at) && !use_rst, (i == abort_at) && use_rst);
            if (i == 0) s = cyc;
        end
        if (!fin) check_int({name, " timeout"}, 0, 1);
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_int({name, " busy after"}, int'(busy), 0);
        check_int({name, " layer_sel after"}, int'(layer_sel), 0);
        if (abort_at >= 0) begin
            check_int({name, " done count"}, done_cnt - d0, 0);
            check_int({name, " hid count"}, hid_cnt - h0, 0);
        end else begin
            check_int({name, " done count"}, done_cnt - d0, 1);
            check_int({name, " hid count"}, hid_cnt - h0, 1);
            check_int({name, " row100 macs"}, row100_cnt - r0, 1);
            check_int({name, " bias pulses"}, bias_cnt - b0, 2);
        end
        if (exp_lat > 0) begin
            check_int({name, " latency"}, last_done_cyc - s, exp_lat);
`ifdef NN_SEQ_CYCLE_CNT_EN
            check_int({name, " cycle_cnt"}, int'(cycle_cnt), exp_lat);
`endif
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_scn("plain",      -1, 0, -1,  1'b0, -1,  -1,  0,  821);
        run_scn("stall_row",  102, 5, -1, 1'b0, -1,  -1,  0,  826);
        run_scn("stall_bias", 820, 2, -1, 1'b0, -1,  -1,  0,  823);
        run_scn("abort",      -1, 0, 402, 1'b0, -1,  -1,  0,  -1);
        run_scn("after_abrt", -1, 0, -1,  1'b0, -1,  -1,  0,  821);
        run_scn("late_start", -1, 0, -1,  1'b0, 800, 821, 0,  821);
        run_scn("rand_stall", -1, 0, -1,  1'b0, -1,  -1,  20, -1);
        run_scn("sync_rst",   -1, 0, 500, 1'b1, -1,  -1,  0,  -1);
        run_scn("rand_busy",  -1, 0, -1,  1'b0, 300, 830, 35, -1);
        run_scn("final",      -1, 0, -1,  1'b0, -1,  -1,  0,  821);
        check_int("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
